// File: rtl/program_loader.sv
// Byte-stream program loader: packs a length-prefixed little-endian byte stream into
// 32-bit words, writes them to instruction memory and holds the core in reset meanwhile.
module program_loader #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] buffer;
  logic        accept;
  logic [15:0] len_full;

  assign accept   = byte_valid && byte_ready;
  assign len_full = {byte_data, len[7:0]};

  // Outputs are assigned alongside each state transition so they are registered
  // values that match the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      buffer     <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE, ERR: begin
          if (start) begin
            state      <= LEN_LO;
            core_rst   <= 1'b1;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            error      <= 1'b0;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data;
            state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_data;
            if (len_full == 16'd0 || len_full > MAX_LEN) begin
              state      <= ERR;
              error      <= 1'b1;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
            end else begin
              word_idx <= '0;
              byte_idx <= '0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            buffer[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_addr   <= {14'd0, word_idx, 2'b00};
              mem_wdata  <= {byte_data, buffer[23:0]};
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          if (word_idx == len - 16'd1) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= DATA;
            byte_ready <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          core_rst <= 1'b0;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
